// File: rtl/keypad_scan_nxm.sv
// keypad_scan_nxm: NxM keypad column scanner with press/release debounce,
// a one-cycle key event strobe and a shift history of the last DIGITS codes.
module keypad_scan_nxm #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4,
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DIGITS = 2,
  localparam int CODE_W = $clog2(NROWS * NCOLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NROWS-1:0]         R,
  output logic [NCOLS-1:0]         C,
  input  logic                     clr_digits,
  output logic                     key_valid,
  output logic [CODE_W-1:0]        key_code,
  output logic [DIGITS*CODE_W-1:0] digits
);
  localparam int RW = NROWS > 1 ? $clog2(NROWS) : 1;
  localparam int CW = NCOLS > 1 ? $clog2(NCOLS) : 1;
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = DIGITS * CODE_W;
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NCOLS - 1);

  if (SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("keypad_scan_nxm: SCAN_CYCLES must be >= 3 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state;
  logic [NROWS-1:0]  r_m, rs;
  logic [CW-1:0]     col, col_nx;
  logic [RW-1:0]     row, low;
  logic [SW-1:0]     dwell;
  logic [BW-1:0]     cnt;
  logic [CODE_W-1:0] code;
  logic              hit;

  always_comb begin
    low = '0;
    for (int i = NROWS - 1; i >= 0; i--) if (rs[i]) low = RW'(i);
    hit = rs[row];
    col_nx = col == C_LAST ? '0 : col + CW'(1);
    code = CODE_W'(row) * CODE_W'(NCOLS) + CODE_W'(col);
  end

  assign C = NCOLS'(1) << col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SCAN;
      r_m <= '0;
      rs <= '0;
      col <= '0;
      row <= '0;
      dwell <= '0;
      cnt <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
      digits <= '0;
    end else begin
      r_m <= R;
      rs <= r_m;
      key_valid <= 1'b0;
      if (clr_digits) digits <= '0;
      case (state)
        SCAN:
          if (dwell == S_LAST) begin
            dwell <= '0;
            if (|rs) begin
              row <= low;
              cnt <= '0;
              state <= DEBOUNCE;
            end else col <= col_nx;
          end else dwell <= dwell + SW'(1);
        DEBOUNCE:
          if (!hit) begin
            state <= SCAN;
            col <= col_nx;
            dwell <= '0;
          end else if (cnt == B_LAST) begin
            key_valid <= 1'b1;
            key_code <= code;
            // a coincident clear leaves only the new code in the newest slot
            digits <= ((clr_digits ? {DW{1'b0}} : digits) << CODE_W) | DW'(code);
            state <= HELD;
          end else cnt <= cnt + BW'(1);
        HELD:
          if (!hit) begin
            cnt <= '0;
            state <= RELEASE;
          end
        RELEASE:
          if (hit) state <= HELD;
          else if (cnt == B_LAST) begin
            state <= SCAN;
            col <= col_nx;
            dwell <= '0;
          end else cnt <= cnt + BW'(1);
        default: state <= SCAN;
      endcase
    end
  end
endmodule
